// File: rtl/irrigation_display_pkg.sv
// Shared constants for the irrigation-mode LED matrix: mode indices, row width
// and the half-column image table (Y-axis symmetric, bit0 = top row).
package irrigation_display_pkg;

    localparam int ROW_W = 7;

    localparam int MODE_SPRINKLER = 0;
    localparam int MODE_DRIPPER   = 1;
    localparam int MODE_OFF       = 2;
    localparam int MODE_FAULT     = 3;

    typedef logic [ROW_W-1:0] row_t;

    localparam row_t SPRINKLER_H0 = 7'h7F;
    localparam row_t SPRINKLER_H1 = 7'h61;
    localparam row_t SPRINKLER_H2 = 7'h46;
    localparam row_t DRIPPER_H0   = 7'h7E;
    localparam row_t DRIPPER_H1   = 7'h7C;
    localparam row_t DRIPPER_H2   = 7'h30;
    localparam row_t OFF_H0       = 7'h00;
    localparam row_t OFF_H1       = 7'h00;
    localparam row_t OFF_H2       = 7'h00;
    localparam row_t FAULT_H0     = 7'h08;
    localparam row_t FAULT_H1     = 7'h36;
    localparam row_t FAULT_H2     = 7'h41;

    // Unknown modes and half-columns beyond h2 read as a dark column.
    function automatic row_t image_lookup(input int mode, input int half_col);
        row_t h0;
        row_t h1;
        row_t h2;
        row_t pat;
        case (mode)
            MODE_SPRINKLER: begin h0 = SPRINKLER_H0; h1 = SPRINKLER_H1; h2 = SPRINKLER_H2; end
            MODE_DRIPPER:   begin h0 = DRIPPER_H0;   h1 = DRIPPER_H1;   h2 = DRIPPER_H2;   end
            MODE_OFF:       begin h0 = OFF_H0;       h1 = OFF_H1;       h2 = OFF_H2;       end
            MODE_FAULT:     begin h0 = FAULT_H0;     h1 = FAULT_H1;     h2 = FAULT_H2;     end
            default:        begin h0 = '0;           h1 = '0;           h2 = '0;           end
        endcase
        case (half_col)
            0:       pat = h0;
            1:       pat = h1;
            2:       pat = h2;
            default: pat = '0;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/irrigation_matrix_scanner_if.sv
// Control and pin-side bundle between the irrigation control FSM (master)
// and the matrix scanner (slave).
interface irrigation_matrix_scanner_if #(
    parameter int NUM_COLS = 5,
    parameter int NUM_ROWS = 7,
    parameter int MODE_W   = 2
);

    logic                enable;
    logic [MODE_W-1:0]   mode_sel;
    logic                mode_load;
    logic                blink_en;
    logic [NUM_COLS-1:0] col_sel_n;
    logic [NUM_ROWS-1:0] row_data;
    logic [MODE_W-1:0]   active_mode;
    logic                frame_start;
    logic                mode_err;

    modport master (
        output enable, mode_sel, mode_load, blink_en,
        input  col_sel_n, row_data, active_mode, frame_start, mode_err
    );

    modport slave (
        input  enable, mode_sel, mode_load, blink_en,
        output col_sel_n, row_data, active_mode, frame_start, mode_err
    );

endinterface

// File: rtl/irrigation_matrix_scanner_image_rom.sv
// Combinational half-column image ROM; widens or trims the stored row pattern
// to the physical row count.
module irrigation_image_rom
    import irrigation_display_pkg::*;
#(
    parameter int NUM_ROWS = ROW_W,
    parameter int MODE_W   = 2,
    parameter int HALF_W   = 2
) (
    input  logic [MODE_W-1:0]   mode,
    input  logic [HALF_W-1:0]   half_col,
    output logic [NUM_ROWS-1:0] row_bits
);

    always_comb begin
        row_bits = NUM_ROWS'(image_lookup(int'(mode), int'(half_col)));
    end

endmodule

// File: rtl/irrigation_matrix_scanner.sv
// Time-multiplexed LED-matrix scanner: one column lit at a time, tear-free mode
// switching at frame boundaries, blink overlay and break-before-make column gaps.
module irrigation_matrix_scanner
    import irrigation_display_pkg::*;
#(
    parameter int NUM_COLS     = 5,
    parameter int NUM_ROWS     = 7,
    parameter int NUM_MODES    = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 50
) (
    input logic                       clk,
    input logic                       rst_n,
    irrigation_matrix_scanner_if.slave bus
);

    localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam int COL_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int CENTER = (NUM_COLS - 1) / 2;
    localparam int HALF_W = (CENTER > 0) ? $clog2(CENTER + 1) : 1;
    localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PRE_W-1:0]    prescaler;
    logic [COL_W-1:0]    col_idx;
    logic [FRM_W-1:0]    frame_cnt;
    logic                blank;
    logic [MODE_W-1:0]   pending;
    logic [MODE_W-1:0]   active_mode;
    logic                mode_err;

    logic                tick;
    logic                frame_end;
    logic                blink_wrap;
    logic                mode_valid;
    logic [COL_W-1:0]    col_dist;
    logic [HALF_W-1:0]   half_col;
    logic [NUM_ROWS-1:0] rom_rows;

    logic [NUM_COLS-1:0] col_sel_n_p1;
    logic [NUM_ROWS-1:0] row_data_p1;
    logic                frame_start_p1;

    assign tick       = bus.enable && (prescaler == PRE_W'(SCAN_DIV - 1));
    assign frame_end  = tick && (col_idx == COL_W'(NUM_COLS - 1));
    assign blink_wrap = (frame_cnt == FRM_W'(BLINK_FRAMES - 1));
    assign mode_valid = int'(bus.mode_sel) < NUM_MODES;

    // Mirror image: distance from the centre column selects the stored half-column.
    assign col_dist = (col_idx >= COL_W'(CENTER)) ? (col_idx - COL_W'(CENTER))
                                                  : (COL_W'(CENTER) - col_idx);
    assign half_col = HALF_W'(col_dist);

    irrigation_image_rom #(
        .NUM_ROWS (NUM_ROWS),
        .MODE_W   (MODE_W),
        .HALF_W   (HALF_W)
    ) u_image_rom (
        .mode     (active_mode),
        .half_col (half_col),
        .row_bits (rom_rows)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            col_idx   <= '0;
            frame_cnt <= '0;
        end else if (!bus.enable) begin
            prescaler <= '0;
            col_idx   <= '0;
            frame_cnt <= '0;
        end else if (tick) begin
            prescaler <= '0;
            col_idx   <= frame_end ? '0 : col_idx + 1'b1;
            if (frame_end) begin
                frame_cnt <= blink_wrap ? '0 : frame_cnt + 1'b1;
            end
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank <= 1'b0;
        end else if (!bus.blink_en) begin
            blank <= 1'b0;
        end else if (frame_end && blink_wrap) begin
            blank <= ~blank;
        end
    end

    // A load coinciding with a frame end lands in pending only; active takes the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            active_mode <= '0;
            mode_err    <= 1'b0;
        end else begin
            if (frame_end) begin
                active_mode <= pending;
            end
            if (bus.mode_load) begin
                if (mode_valid) begin
                    pending <= bus.mode_sel;
                end else begin
                    mode_err <= 1'b1;
                end
            end
        end
    end

    // ---- output stage p1: dark on the cycle after each tick and while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_sel_n_p1   <= '1;
            row_data_p1    <= '0;
            frame_start_p1 <= 1'b0;
        end else if (!bus.enable || tick) begin
            col_sel_n_p1   <= '1;
            row_data_p1    <= '0;
            frame_start_p1 <= 1'b0;
        end else begin
            col_sel_n_p1   <= ~(NUM_COLS'(1) << col_idx);
            row_data_p1    <= (blank && bus.blink_en) ? '0 : rom_rows;
            frame_start_p1 <= (col_idx == '0) && (prescaler == '0);
        end
    end

    assign bus.col_sel_n   = col_sel_n_p1;
    assign bus.row_data    = row_data_p1;
    assign bus.frame_start = frame_start_p1;
    assign bus.active_mode = active_mode;
    assign bus.mode_err    = mode_err;

endmodule
